// File: rtl/rf_wr_arbiter.sv
// Round-robin arbiter sharing the register-file write port between N_REQ writeback
// sources, with a registered write port and a per-register pending-write scoreboard.
module rf_wr_arbiter #(
    parameter int N_REQ  = 2,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    localparam int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1,
    localparam int N_REG = 2 ** ADDR_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req_valid,
    output logic [N_REQ-1:0]          req_ready,
    input  logic [N_REQ*ADDR_W-1:0]   req_addr,
    input  logic [N_REQ*DATA_W-1:0]   req_data,
    input  logic                      rsv_valid,
    input  logic [ADDR_W-1:0]         rsv_addr,
    output logic                      rf_wen,
    output logic [ADDR_W-1:0]         rf_waddr,
    output logic [DATA_W-1:0]         rf_wdata,
    output logic [ID_W-1:0]           grant_id,
    output logic [N_REG-1:0]          busy
);

    logic [ID_W-1:0]   ptr;
    logic [ID_W-1:0]   gnt_idx;
    logic              found;
    logic              xfer;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;
    logic [ID_W-1:0]   ptr_nxt;
    logic [N_REG-1:0]  busy_nxt;

    // Walk P, P+1, ... modulo N_REQ and take the first valid requester.
    always_comb begin
        logic [ID_W:0]   sum;
        logic [ID_W-1:0] idx;
        // NOTE: every combinational output gets a default before any branch, so no latch is inferred.
        found   = 1'b0;
        gnt_idx = '0;
        sum     = '0;
        idx     = '0;
        for (int k = 0; k < N_REQ; k++) begin
            sum = {1'b0, ptr} + (ID_W+1)'(k);
            if (sum >= (ID_W+1)'(N_REQ))
                sum = sum - (ID_W+1)'(N_REQ);
            idx = sum[ID_W-1:0];
            if (!found && req_valid[idx]) begin
                found   = 1'b1;
                gnt_idx = idx;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (rst && found)
            req_ready[gnt_idx] = 1'b1;
    end

    assign xfer     = |req_ready;
    assign sel_addr = req_addr[gnt_idx*ADDR_W +: ADDR_W];
    assign sel_data = req_data[gnt_idx*DATA_W +: DATA_W];
    assign ptr_nxt  = (gnt_idx == ID_W'(N_REQ-1)) ? '0 : gnt_idx + 1'b1;

    // Clear on the write first, then apply the reservation so a same-cycle set wins.
    always_comb begin
        busy_nxt = busy;
        if (xfer)
            busy_nxt[sel_addr] = 1'b0;
        if (rsv_valid && (rsv_addr != '0))
            busy_nxt[rsv_addr] = 1'b1;
        busy_nxt[0] = 1'b0;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rf_wen   <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
            grant_id <= '0;
            ptr      <= '0;
            busy     <= '0;
        end else begin
            rf_wen <= xfer && (sel_addr != '0);
            if (xfer) begin
                rf_waddr <= sel_addr;
                rf_wdata <= sel_data;
                grant_id <= gnt_idx;
                ptr      <= ptr_nxt;
            end
            busy <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_rf_wr_arbiter.sv
// Self-checking bench for rf_wr_arbiter: directed scenarios followed by randomized
// traffic, all compared against a transaction-level reference model.
module tb_rf_wr_arbiter;

    localparam int N  = 2;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 2 ** AW;

    logic              clk;
    logic              rst;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_ready;
    logic [N*AW-1:0]   req_addr;
    logic [N*DW-1:0]   req_data;
    logic              rsv_valid;
    logic [AW-1:0]     rsv_addr;
    logic              rf_wen;
    logic [AW-1:0]     rf_waddr;
    logic [DW-1:0]     rf_wdata;
    logic [0:0]        grant_id;
    logic [NR-1:0]     busy;

    rf_wr_arbiter #(.N_REQ(N), .DATA_W(DW), .ADDR_W(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .rsv_valid (rsv_valid),
        .rsv_addr  (rsv_addr),
        .rf_wen    (rf_wen),
        .rf_waddr  (rf_waddr),
        .rf_wdata  (rf_wdata),
        .grant_id  (grant_id),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int            m_ptr   = 0;
    int            m_grant = -1;
    logic          m_wen   = 1'b0;
    logic [AW-1:0] m_waddr = '0;
    logic [DW-1:0] m_wdata = '0;
    int            m_gid   = 0;
    logic [NR-1:0] m_busy  = '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic set_req(input int i, input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_valid[i]          = v;
        req_addr[i*AW +: AW]  = a;
        req_data[i*DW +: DW]  = d;
    endtask

    // One clock: check the grant mid-cycle, advance the model, check registered outputs after the edge.
    task automatic step();
        int            g;
        logic [N-1:0]  exp_rdy;
        logic [AW-1:0] a;
        g = -1;
        if (rst)
            for (int k = 0; k < N; k++)
                if (g < 0 && req_valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;

        @(negedge clk);
        check("req_ready", 64'(req_ready), 64'(exp_rdy));

        if (!rst) begin
            m_wen = 1'b0; m_waddr = '0; m_wdata = '0; m_gid = 0; m_busy = '0; m_ptr = 0;
        end else begin
            m_wen = 1'b0;
            if (g >= 0) begin
                a         = req_addr[g*AW +: AW];
                m_wen     = (a != 0);
                m_waddr   = a;
                m_wdata   = req_data[g*DW +: DW];
                m_gid     = g;
                m_ptr     = (g + 1) % N;
                m_busy[a] = 1'b0;
            end
            if (rsv_valid && rsv_addr != 0) m_busy[rsv_addr] = 1'b1;
            m_busy[0] = 1'b0;
        end
        m_grant = g;

        @(posedge clk);
        #1;
        check("rf_wen",   64'(rf_wen),   64'(m_wen));
        check("rf_waddr", 64'(rf_waddr), 64'(m_waddr));
        check("rf_wdata", 64'(rf_wdata), 64'(m_wdata));
        check("grant_id", 64'(grant_id), 64'(m_gid));
        check("busy",     64'(busy),     64'(m_busy));
    endtask

    initial begin
        rst       = 1'b0;
        req_valid = '1;
        req_addr  = '0;
        req_data  = '0;
        rsv_valid = 1'b0;
        rsv_addr  = '0;
        set_req(0, 1'b1, 5'd3, 32'h1111_1111);
        set_req(1, 1'b1, 5'd4, 32'h2222_2222);
        @(posedge clk);
        #1;

        // Reset held two cycles with every requester valid
        step();
        step();
        check("rst_wen",  64'(rf_wen), 64'd0);
        check("rst_busy", 64'(busy),   64'd0);

        // Single write to r5; first grant after release must go to requester 0
        rst = 1'b1;
        req_valid = '0;
        set_req(0, 1'b1, 5'd5, 32'hDEAD_BEEF);
        step();
        check("t2_wen",   64'(rf_wen),   64'd1);
        check("t2_waddr", 64'(rf_waddr), 64'd5);
        check("t2_wdata", 64'(rf_wdata), 64'hDEAD_BEEF);
        check("t2_gid",   64'(grant_id), 64'd0);
        req_valid[0] = 1'b0;

        // Write to r0 from requester 1: accepted, no write, pointer wraps to 0
        set_req(1, 1'b1, 5'd0, 32'h1234_5678);
        step();
        check("t4_wen", 64'(rf_wen), 64'd0);
        req_valid[1] = 1'b0;

        // Contention: both valid for four cycles
        set_req(0, 1'b1, 5'd10, 32'hA000_0000);
        set_req(1, 1'b1, 5'd20, 32'hB000_0000);
        for (int c = 0; c < 4; c++) begin
            step();
            check("t3_gid", 64'(grant_id), 64'(c % 2));
            check("t3_wen", 64'(rf_wen),   64'd1);
            if (m_grant >= 0)
                set_req(m_grant, 1'b1, AW'(11 + c), DW'(32'hC000_0000 + c));
        end
        req_valid = '0;

        // Scoreboard: reserve 7, write 7, then reserve and write 9 together
        rsv_valid = 1'b1;
        rsv_addr  = 5'd7;
        step();
        rsv_valid = 1'b0;
        check("t5_busy7_set", 64'(busy[7]), 64'd1);
        set_req(0, 1'b1, 5'd7, 32'h0000_0007);
        step();
        req_valid = '0;
        check("t5_busy7_clr", 64'(busy[7]), 64'd0);
        rsv_valid = 1'b1;
        rsv_addr  = 5'd9;
        set_req(1, 1'b1, 5'd9, 32'h0000_0009);
        step();
        rsv_valid = 1'b0;
        req_valid = '0;
        check("t5_busy9", 64'(busy[9]), 64'd1);

        // Reset on a transfer edge
        set_req(0, 1'b1, 5'd3, 32'h3333_3333);
        rsv_valid = 1'b1;
        rsv_addr  = 5'd4;
        rst = 1'b0;
        step();
        check("t6_wen",  64'(rf_wen), 64'd0);
        check("t6_busy", 64'(busy),   64'd0);
        rst = 1'b1;
        rsv_valid = 1'b0;

        // Randomized traffic; valid only drops after acceptance
        for (int n = 0; n < 400; n++) begin
            step();
            for (int i = 0; i < N; i++) begin
                if (req_valid[i] && m_grant == i)
                    req_valid[i] = 1'b0;
                if (!req_valid[i] && $urandom_range(0, 2) != 0)
                    set_req(i, 1'b1,
                            ($urandom_range(0, 7) == 0) ? AW'(0) : AW'($urandom_range(1, NR-1)),
                            DW'($urandom));
            end
            rsv_valid = ($urandom_range(0, 2) == 0);
            rsv_addr  = AW'($urandom_range(0, NR-1));
            rst       = ($urandom_range(0, 49) != 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
